// File: rtl/noc_msg_pkg.sv
// Shared NoC message definitions: field width, record layout and header command codes.
package noc_msg_pkg;
  localparam int MSG_W = 8;

  typedef struct packed {
    logic [MSG_W-1:0] al_dl;
    logic [MSG_W-1:0] d_id;
    logic [MSG_W-1:0] s_id;
    logic [MSG_W-1:0] m_addr;
    logic [MSG_W-1:0] m_data;
  } msg_rec_t;

  localparam logic [2:0] READ_RESP  = 3'd3;
  localparam logic [2:0] WRITE_RESP = 3'd4;
  localparam logic [2:0] MESSAGE    = 3'd5;

  // Header byte layout is {Alen[7:6], Dlen[5:3], cmd[2:0]}.
  function automatic logic [2:0] msg_cmd(input msg_rec_t rec);
    return rec.al_dl[2:0];
  endfunction
endpackage

// File: rtl/msg_record_fifo_if.sv
// Producer/consumer bundle for the message record FIFO; master is the
// generator/serializer side, slave is the FIFO.
interface msg_record_fifo_if #(
  parameter int W = noc_msg_pkg::MSG_W
);
  logic [W-1:0] Al_Dlin, D_IDin, S_IDin, M_Addrin, M_Datain;
  logic         writep, readp;
  logic [W-1:0] Al_Dl, D_IDout, S_IDout, M_Addrout, M_Dataout;
  logic         emptyp, fullp;

  modport master (
    output Al_Dlin, D_IDin, S_IDin, M_Addrin, M_Datain, writep, readp,
    input  Al_Dl, D_IDout, S_IDout, M_Addrout, M_Dataout, emptyp, fullp
  );

  modport slave (
    input  Al_Dlin, D_IDin, S_IDin, M_Addrin, M_Datain, writep, readp,
    output Al_Dl, D_IDout, S_IDout, M_Addrout, M_Dataout, emptyp, fullp
  );
endinterface

// File: rtl/sync_fifo_core.sv
// Generic first-word-fall-through FIFO with registered occupancy count;
// the head entry is combinationally visible and forced to zero while empty.
module sync_fifo_core #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  // A full FIFO still takes a write when the same edge frees the head slot.
  assign w_pop   = rst_n & i_rd & ~o_empty;
  assign w_push  = rst_n & i_wr & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/msg_record_fifo.sv
// FWFT queue of 5-byte NoC message records between the response/message
// generators and the frm_data serializer.
module msg_record_fifo
  import noc_msg_pkg::*;
#(
  parameter int W     = MSG_W,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  msg_record_fifo_if.slave   bus
);
  msg_rec_t w_wr_rec, w_rd_rec;

  assign w_wr_rec = {bus.Al_Dlin, bus.D_IDin, bus.S_IDin, bus.M_Addrin, bus.M_Datain};

  sync_fifo_core #(
    .WIDTH (5*W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset),
    .i_wr    (bus.writep),
    .i_rd    (bus.readp),
    .i_data  (w_wr_rec),
    .o_data  (w_rd_rec),
    .o_empty (bus.emptyp),
    .o_full  (bus.fullp)
  );

  assign bus.Al_Dl     = w_rd_rec.al_dl;
  assign bus.D_IDout   = w_rd_rec.d_id;
  assign bus.S_IDout   = w_rd_rec.s_id;
  assign bus.M_Addrout = w_rd_rec.m_addr;
  assign bus.M_Dataout = w_rd_rec.m_data;
endmodule

// File: tb/tb_msg_record_fifo.sv
// Directed plus random checks of msg_record_fifo against a queue-based model.
module tb_msg_record_fifo;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [39:0] q[$];

  msg_record_fifo_if #(.W(8)) bus ();

  msg_record_fifo #(.W(8), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  function automatic logic [39:0] head();
    return (q.size() != 0) ? q[0] : 40'h0;
  endfunction

  function automatic logic [39:0] outs();
    return {bus.Al_Dl, bus.D_IDout, bus.S_IDout, bus.M_Addrout, bus.M_Dataout};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data"},  outs(), head());
    chk({tag, "_empty"}, {39'h0, bus.emptyp}, {39'h0, q.size() == 0});
    chk({tag, "_full"},  {39'h0, bus.fullp},  {39'h0, q.size() == DEPTH});
  endtask

  // One clock: drive at negedge, apply the queue rules at the edge, check 1ns later.
  task automatic step(input logic wr, input logic rd, input logic [39:0] d, input string tag);
    bit was_empty, was_full;
    @(negedge clk);
    bus.writep = wr;
    bus.readp  = rd;
    {bus.Al_Dlin, bus.D_IDin, bus.S_IDin, bus.M_Addrin, bus.M_Datain} = d;
    @(posedge clk);
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if (rd && !was_empty) void'(q.pop_front());
    if (wr && (!was_full || rd)) q.push_back(d);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [39:0] d;
    bus.writep = 1'b0; bus.readp = 1'b0;
    {bus.Al_Dlin, bus.D_IDin, bus.S_IDin, bus.M_Addrin, bus.M_Datain} = 40'h0;

    #1 reset = 1'b0;
    #1 chk_all("reset");
    @(negedge clk); reset = 1'b1;

    // First push visible after one edge.
    step(1, 0, 40'h04_11_22_08_07, "push1");
    chk("push1_exact", outs(), 40'h04_11_22_08_07);
    step(0, 1, 40'h0, "pop1");

    // Ordered pops of A, B, C.
    step(1, 0, 40'h03_01_02_10_AA, "pushA");
    step(1, 0, 40'h04_03_04_20_BB, "pushB");
    step(1, 0, 40'h05_05_06_30_CC, "pushC");
    chk("headA", outs(), 40'h03_01_02_10_AA);
    step(0, 1, 40'h0, "popA");
    chk("headB", outs(), 40'h04_03_04_20_BB);
    step(0, 1, 40'h0, "popB");
    chk("headC", outs(), 40'h05_05_06_30_CC);
    step(0, 1, 40'h0, "popC");
    chk("abc_empty", {39'h0, bus.emptyp}, 40'h1);
    chk("abc_zero", outs(), 40'h0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) begin
      d = rnd40(); d[7:0] = 8'(i);
      step(1, 0, d, "fill");
    end
    chk("fill_full", {39'h0, bus.fullp}, 40'h1);
    step(1, 0, 40'hFF_FF_FF_FF_FF, "ovf");
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_byte", {32'h0, bus.M_Dataout}, 40'(i));
      step(0, 1, 40'h0, "drain");
    end
    chk("drain_empty", {39'h0, bus.emptyp}, 40'h1);

    // Steady-state read+write with 3 queued, crossing the pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 0, rnd40(), "pre3");
    for (int i = 0; i < 4; i++) step(1, 1, rnd40(), "rw3");
    chk("rw3_count", 40'(q.size()), 40'd3);
    for (int i = 0; i < 3; i++) step(0, 1, 40'h0, "rw3_drain");

    // Underflow attempts, then a clean push.
    step(0, 1, 40'h0, "uflow1");
    step(0, 1, 40'h0, "uflow2");
    step(1, 1, 40'h05_AB_CD_EF_12, "rw_empty");
    chk("rw_empty_exact", outs(), 40'h05_AB_CD_EF_12);
    step(0, 1, 40'h0, "rw_empty_pop");

    // Read+write while full replaces the oldest in order.
    for (int i = 0; i < DEPTH; i++) step(1, 0, rnd40(), "fill2");
    for (int i = 0; i < 3; i++) step(1, 1, rnd40(), "rw_full");
    chk("rw_full_flag", {39'h0, bus.fullp}, 40'h1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 40'h0, "drain2");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), rnd40(), "rand");

    // Asynchronous reset mid-cycle with records queued.
    while (q.size() < 5) step(1, 0, rnd40(), "pre_rst");
    while (q.size() > 5) step(0, 1, 40'h0, "pre_rst");
    @(negedge clk);
    bus.writep = 1'b0; bus.readp = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    q.delete();
    #1 chk_all("async_rst");
    chk("async_rst_zero", outs(), 40'h0);
    @(negedge clk); reset = 1'b1;
    step(1, 0, 40'h03_44_55_66_77, "post_rst");
    chk("post_rst_exact", outs(), 40'h03_44_55_66_77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
